// File: rtl/fifo_wr_arbiter.sv
// Round-robin, credit-flow-controlled write arbiter sharing one FIFO write port
// among N producers, with a per-requester burst limit before priority rotates.
module fifo_wr_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N-1:0]               req_valid,
  input  logic [N*WIDTH-1:0]         req_data,
  output logic [N-1:0]               req_ready,
  input  logic                       credit_return,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_wr_data,
  output logic [$clog2(N)-1:0]       fifo_wr_src,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       credit_err
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    last_id_q, last_id_d;
  logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [CW-1:0]    credits_q, credits_d;
  logic             credit_err_q, credit_err_d;
  logic             wr_en_q, wr_en_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [IW-1:0]    wr_src_q, wr_src_d;

  logic             win_vld;
  logic [IW-1:0]    win_id;
  logic [IW-1:0]    scan_id;
  logic             accept;
  logic [BW-1:0]    cnt_nxt;

  // Index addition modulo N; operands are always below N so one subtraction suffices.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int unsigned b);
    logic [IW:0] s;
    s = {1'b0, a} + (IW+1)'(b);
    if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
    return s[IW-1:0];
  endfunction

  // Scan from rr_ptr downward in priority; the lowest offset written last wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    scan_id = '0;
    for (int unsigned k = N; k > 0; k--) begin
      scan_id = wrap_add(rr_ptr_q, k - 1);
      if (req_valid[scan_id]) begin
        win_vld = 1'b1;
        win_id  = scan_id;
      end
    end
  end

  assign accept = win_vld & (credits_q != '0);

  always_comb begin
    req_ready = '0;
    if (accept && !reset) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    last_id_d    = last_id_q;
    burst_cnt_d  = burst_cnt_q;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_src_d     = wr_src_q;
    cnt_nxt      = (win_id == last_id_q) ? burst_cnt_q + BW'(1) : BW'(1);

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_data_d = req_data[win_id*WIDTH +: WIDTH];
      wr_src_d  = win_id;
      last_id_d = win_id;
      if (cnt_nxt == BW'(MAX_BURST)) begin
        rr_ptr_d    = wrap_add(win_id, 1);
        burst_cnt_d = '0;
      end else begin
        rr_ptr_d    = win_id;
        burst_cnt_d = cnt_nxt;
      end
    end

    // Simultaneous accept and return cancel, even at a full credit pool.
    case ({accept, credit_return})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CW'(DEPTH)) credit_err_d = 1'b1;
        else                         credits_d    = credits_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      last_id_q    <= '0;
      burst_cnt_q  <= '0;
      credits_q    <= CW'(DEPTH);
      credit_err_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_src_q     <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      last_id_q    <= last_id_d;
      burst_cnt_q  <= burst_cnt_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_src_q     <= wr_src_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign fifo_wr_src  = wr_src_q;
  assign credits      = credits_q;
  assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           credit_return;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wr_data;
  logic [1:0]     fifo_wr_src;
  logic [4:0]     credits;
  logic           credit_err;

  fifo_wr_arbiter #(.N(N), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .credit_return(credit_return), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_src(fifo_wr_src), .credits(credits),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  logic           d_reset;
  logic [N-1:0]   d_valid;
  logic [N*W-1:0] d_data;
  logic           d_ret;

  // Model state: priority pointer, burst owner/length, credit pool, expected write port.
  int         m_rr, m_last, m_cnt, m_cred;
  bit         m_err, m_en;
  logic [W-1:0] m_data;
  int         m_src;

  int n_vec = 0;
  int n_err = 0;
  int obs_src[$];
  int exp_rot[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
  int exp_brk[7]  = '{1,1,3,3,3,3,1};
  int exp_rst[5]  = '{0,0,0,0,1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_last = 0; m_cnt = 0; m_cred = D;
    m_err = 0; m_en = 0; m_data = '0; m_src = 0;
  endtask

  // One clock: drive at negedge, compare 1ns later, then advance the model for the coming edge.
  task automatic cycle();
    int w;
    int c;
    bit found;
    bit acc;
    logic [N-1:0] exp_rdy;
    d_data = (N*W)'($urandom);
    @(negedge clk);
    reset = d_reset; req_valid = d_valid; req_data = d_data; credit_return = d_ret;
    if (d_reset) model_reset();
    #1;
    found = 0; w = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && d_valid[(m_rr + k) % N]) begin
        found = 1;
        w = (m_rr + k) % N;
      end
    end
    acc = found && (m_cred > 0) && !d_reset;
    exp_rdy = acc ? (N'(1) << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(m_en));
    chk("credits", 32'(credits), 32'(m_cred));
    chk("credit_err", 32'(credit_err), 32'(m_err));
    if (m_en) begin
      chk("fifo_wr_data", 32'(fifo_wr_data), 32'(m_data));
      chk("fifo_wr_src", 32'(fifo_wr_src), 32'(m_src));
    end
    if (fifo_wr_en === 1'b1) obs_src.push_back(int'(fifo_wr_src));
    if (!d_reset) begin
      m_en = acc;
      if (acc) begin
        m_data = d_data[w*W +: W];
        m_src  = w;
        c = (w == m_last) ? m_cnt + 1 : 1;
        m_last = w;
        if (c == MB) begin
          m_rr = (w + 1) % N; m_cnt = 0;
        end else begin
          m_rr = w; m_cnt = c;
        end
      end
      if (acc && !d_ret) m_cred = m_cred - 1;
      else if (!acc && d_ret) begin
        if (m_cred == D) m_err = 1;
        else             m_cred = m_cred + 1;
      end
    end
  endtask

  task automatic do_reset();
    d_reset = 1; d_valid = '0; d_ret = 0;
    cycle();
    d_reset = 0;
  endtask

  task automatic run(input logic [N-1:0] v, input logic r, input int n);
    d_valid = v; d_ret = r;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int pct;
    d_reset = 1; d_valid = '0; d_ret = 0; d_data = '0;
    model_reset();

    // Reset with random inputs, then a lone requester 2.
    for (int i = 0; i < 3; i++) begin
      d_valid = N'($urandom); d_ret = 1'($urandom);
      cycle();
    end
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_credits", 32'(credits), 32'd16);
    d_reset = 0;
    run(4'b0100, 0, 1);
    chk("first_ready", 32'(req_ready), 32'b0100);

    // Credit exhaustion and a single returned credit.
    do_reset(); obs_src.delete();
    run(4'b0001, 0, 20);
    chk("exh_pulses", 32'(obs_src.size()), 32'd16);
    chk("exh_credits", 32'(credits), 32'd0);
    chk("exh_ready", 32'(req_ready), 32'd0);
    obs_src.delete();
    run(4'b0001, 1, 1);
    run(4'b0001, 0, 5);
    chk("ret_pulses", 32'(obs_src.size()), 32'd1);

    // Fair rotation with all requesters busy.
    do_reset(); obs_src.delete();
    run(4'b1111, 1, 18);
    chk("rot_len", 32'(obs_src.size()), 32'd17);
    if (obs_src.size() >= 17)
      for (int i = 0; i < 17; i++) chk("rot_src", 32'(obs_src[i]), 32'(exp_rot[i]));
    chk("rot_err", 32'(credit_err), 32'd0);

    // Burst break when the locked requester drops out.
    do_reset(); obs_src.delete();
    run(4'b1010, 1, 2);
    run(4'b1000, 1, 4);
    run(4'b1010, 1, 1);
    run(4'b0000, 1, 1);
    chk("brk_len", 32'(obs_src.size()), 32'd7);
    if (obs_src.size() >= 7)
      for (int i = 0; i < 7; i++) chk("brk_src", 32'(obs_src[i]), 32'(exp_brk[i]));

    // Accept and return together at 5 credits.
    do_reset();
    run(4'b0001, 0, 11);
    run(4'b0001, 1, 1);
    chk("pre_sim_credits", 32'(credits), 32'd5);
    run(4'b0000, 0, 1);
    chk("sim_credits", 32'(credits), 32'd5);

    // Over-return at a full pool is sticky until reset.
    do_reset();
    run(4'b0000, 1, 1);
    run(4'b0000, 0, 1);
    chk("ovf_credits", 32'(credits), 32'd16);
    chk("ovf_err", 32'(credit_err), 32'd1);
    for (int i = 0; i < 5; i++) run(N'($urandom), 1'($urandom), 1);
    chk("ovf_sticky", 32'(credit_err), 32'd1);
    do_reset();
    chk("ovf_clear", 32'(credit_err), 32'd0);

    // Reset during a burst drops the in-flight beat and restarts the burst count.
    do_reset();
    run(4'b0001, 0, 3);
    d_reset = 1; d_valid = 4'b0001; cycle();
    chk("mid_en", 32'(fifo_wr_en), 32'd0);
    d_reset = 0; obs_src.delete();
    run(4'b0011, 0, 1);
    chk("mid_credits", 32'(credits), 32'd16);
    chk("mid_ready", 32'(req_ready), 32'b0001);
    run(4'b0011, 0, 4);
    run(4'b0000, 0, 2);
    chk("mid_len", 32'(obs_src.size()), 32'd5);
    if (obs_src.size() >= 5)
      for (int i = 0; i < 5; i++) chk("mid_src", 32'(obs_src[i]), 32'(exp_rst[i]));

    // Randomized traffic with varying credit return rates and occasional resets.
    do_reset();
    pct = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) pct = (i / 100 % 3 == 0) ? 20 : ((i / 100 % 3 == 1) ? 60 : 97);
      d_reset = ($urandom_range(0, 249) == 0);
      d_valid = ($urandom_range(0, 3) == 0) ? N'($urandom) & N'($urandom) : N'($urandom);
      d_ret   = ($urandom_range(0, 99) < pct);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `sync_fifo` write port among N producers. It uses credit-based flow control: it tracks FIFO occupancy with its own credit counter instead of the FIFO's registered `full` flag, so it never issues a write the FIFO cannot store. It sits directly in front of the FIFO write port. The FIFO consumer returns one credit per entry it pops.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8)
- `WIDTH`, 8: data width, equal to the FIFO `WIDTH`
- `DEPTH`, 16: FIFO depth, equal to the FIFO `DEPTH`; initial credit count
- `MAX_BURST`, 4: maximum consecutive accepts for one requester before priority rotates (≥1)

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  N  requester i has a beat offered
- `req_data`  in  N*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- `req_ready`  out  N  one-hot or zero; beat from requester i is accepted when `req_valid[i] & req_ready[i]`
- `credit_return`  in  1  one-cycle pulse per entry popped from the FIFO
- `fifo_wr_en`  out  1  registered write strobe to the FIFO `wr_en`
- `fifo_wr_data`  out  WIDTH  registered data to the FIFO `write_data`
- `fifo_wr_src`  out  $clog2(N)  index of the requester that produced the current `fifo_wr_en` beat
- `credits`  out  $clog2(DEPTH+1)  current free-entry count
- `credit_err`  out  1  sticky; a credit returned while `credits == DEPTH`

## Operation
- **State:** `rr_ptr` (highest-priority index), `last_id`, `burst_cnt` (0..MAX_BURST-1), `credits`.
- **Winner selection (combinational):**
  - Scan `rr_ptr`, `rr_ptr+1`, … modulo N.
  - The winner `w` is the first index with `req_valid` set.
  - `req_ready[w] = 1` only if a winner exists and `credits != 0`. All other `req_ready` bits are 0.
  - `req_ready` must not depend on `req_data`.
- **Accept:** an accept occurs when `req_valid[w] & req_ready[w]`. On an accept:
  - Register `fifo_wr_en = 1`, `fifo_wr_data = req_data[w]`, `fifo_wr_src = w`.
  - Let `cnt' = (w == last_id) ? burst_cnt + 1 : 1`.
  - If `cnt' == MAX_BURST`: `rr_ptr <= (w + 1) mod N`, `burst_cnt <= 0`.
  - Otherwise: `rr_ptr <= w`, `burst_cnt <= cnt'`.
  - In both cases `last_id <= w`.
- **No accept:** `fifo_wr_en <= 0`. `fifo_wr_data` and `fifo_wr_src` hold their values. `rr_ptr`, `last_id` and `burst_cnt` are unchanged.
- **Credits:** one update per cycle.
  - Accept only: decrement by 1.
  - `credit_return` only: increment by 1, unless `credits == DEPTH`. In that case hold the value and set `credit_err`.
  - Accept and `credit_return` together: unchanged. This holds even when `credits == DEPTH`, because the net effect is legal.
  - The counter never wraps below 0 or above DEPTH.
- **Locked requester drops `req_valid`:** the scan continues from `rr_ptr` to the next valid requester. That requester's first accept gives `cnt' = 1`.
- `credit_err` clears only on reset.

## Timing
- **Reset values:**
  - `req_ready` = 0 (combinationally, while `reset` is high)
  - `fifo_wr_en` = 0, `fifo_wr_data` = 0, `fifo_wr_src` = 0
  - `credits` = DEPTH, `credit_err` = 0
  - `rr_ptr` = 0, `last_id` = 0, `burst_cnt` = 0
- **Latency:** an accept at edge k appears as `fifo_wr_en` = 1 in the cycle after edge k, i.e. one cycle. The FIFO captures the beat at edge k+1.
- **Throughput:** one accept per cycle while `credits > 0`.
- **Credit visibility:** `credits` reflects every accept before it reaches the FIFO. The FIFO's registered `full` lag is therefore never exercised.
- **Credit availability after a return:** a `credit_return` at edge k makes the credit usable for an accept evaluated in cycle k+1.
- **Reset mid-burst:** the in-flight registered beat is dropped (`fifo_wr_en` forced to 0). The FIFO must be reset on the same `reset`.

## Test plan
1. **Reset check:** assert `reset` with random inputs → `req_ready` = 0, `fifo_wr_en` = 0, `credits` = 16, `credit_err` = 0. After release, requester 2 alone valid → `req_ready` = 4'b0100.
2. **Credit exhaustion:** requester 0 valid for 20 cycles, no returns → exactly 16 `fifo_wr_en` pulses, `credits` reaches 0, `req_ready` stays 0. Then one `credit_return` → exactly one more accept.
3. **Fair rotation:** all 4 requesters valid continuously, credits replenished each cycle → `fifo_wr_src` sequence 0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0…
4. **Burst break:** requester 1 holds valid for 2 beats then drops, requesters 1 and 3 valid → source sequence 1,1,3,3,3,3. After that, requester 1 regains the grant (`rr_ptr` wrapped to 0; 0 is idle so 1 wins).
5. **Simultaneous credit events:**
   - Accept and `credit_return` in the same cycle at `credits` = 5 → stays 5.
   - `credit_return` alone at `credits` = 16 → stays 16, `credit_err` = 1, and it remains 1 until reset.
6. **Reset mid-burst:** assert `reset` while requester 0 is on its 3rd beat → `fifo_wr_en` drops immediately. After release, `credits` = 16 and the first grant goes to requester 0 with `burst_cnt` restarting at 1.
